lut_interp_pipe: RTL and testbench

Pipelined piecewise-linear interpolator that sits directly downstream of a gate-activation LUT (16-entry signed base/next table) in the LSTM gate datapaths. It splits each fixed-point pre-activation into a segment address and a fraction, and drives the LUT address from a register. From the returned `base` / `next__data` pair it produces `y = base + ((next - base) * frac) >> FRAC_W`. Valid/ready handshakes on both sides allow it to stall under back-pressure from the following multiply stage.

---
 rtl/lut_interp_pipe.sv | 87 ++++++++
 tb/tb_lut_interp_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_interp_pipe.sv
// Three-stage piecewise-linear interpolator behind a base/next activation LUT.
// Define LUT_INTERP_ROUND_EN to round the fractional product half-up instead of flooring.
module lut_interp_pipe #(
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] x,
    output logic [ADDR_W-1:0]        lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y
);

    localparam int X_W = ADDR_W + FRAC_W;
    localparam int P_W = DATA_W + FRAC_W + 2;

    logic                     adv;

    logic                     s1_valid;
    logic [ADDR_W-1:0]        s1_addr;
    logic [FRAC_W-1:0]        s1_frac;

    logic                     s2_valid;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [DATA_W:0]   s2_delta;
    logic [FRAC_W-1:0]        s2_frac;

    logic                     s3_valid;
    logic signed [DATA_W-1:0] s3_y;

    logic signed [DATA_W:0]   delta_c;
    logic signed [P_W-1:0]    prod;
    logic signed [P_W-1:0]    prod_adj;
    logic signed [P_W-1:0]    sh;

    // Whole pipeline advances together; it only freezes when the output is stuck.
    assign adv         = !s3_valid || out_ready;
    assign in_ready    = adv;
    assign lut_address = s1_addr;
    assign out_valid   = s3_valid;
    assign y           = s3_y;

    assign delta_c = (DATA_W+1)'(lut_next) - (DATA_W+1)'(lut_base);
    assign prod    = s2_delta * $signed({1'b0, s2_frac});

`ifdef LUT_INTERP_ROUND_EN
    localparam logic signed [P_W-1:0] HALF = P_W'(1) << (FRAC_W - 1);
    assign prod_adj = prod + HALF;
`else
    assign prod_adj = prod;
`endif

    assign sh = prod_adj >>> FRAC_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_frac  <= '0;
            s2_valid <= 1'b0;
            s2_base  <= '0;
            s2_delta <= '0;
            s2_frac  <= '0;
            s3_valid <= 1'b0;
            s3_y     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_addr  <= x[X_W-1:FRAC_W];
            s1_frac  <= x[FRAC_W-1:0];
            s2_valid <= s1_valid;
            s2_base  <= lut_base;
            s2_delta <= delta_c;
            s2_frac  <= s1_frac;
            s3_valid <= s2_valid;
            // Result lies between base and next, so dropping the upper bits is exact.
            s3_y     <= DATA_W'(s2_base + sh);
        end
    end

endmodule

// File: tb/tb_lut_interp_pipe.sv
// Scoreboard bench for lut_interp_pipe with a behavioural sigmoid LUT and two stub LUTs.
// Honours LUT_INTERP_ROUND_EN for the rounding-dependent expectations.
module tb_lut_interp_pipe;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        x;
    logic [3:0]        lut_address;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] y;

    int tests = 0;
    int fails = 0;
    int lut_mode = 0;
    logic signed [7:0] expq[$];

    lut_interp_pipe #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] sig_entry(input int i);
        return 8'(i * 16);
    endfunction

    // Sigmoid table: top segment wraps to entry 0, positive-maximum segment repeats itself.
    always_comb begin
        lut_base = '0;
        lut_next = '0;
        case (lut_mode)
            1: begin lut_base = 8'sd10; lut_next = 8'sd13; end
            2: begin lut_base = 8'sd10; lut_next = 8'sd7;  end
            default: begin
                lut_base = sig_entry(int'(lut_address));
                if (lut_address == 4'd7)       lut_next = lut_base;
                else if (lut_address == 4'd15) lut_next = sig_entry(0);
                else                           lut_next = sig_entry(int'(lut_address) + 1);
            end
        endcase
    end

    function automatic int model_y(input logic [7:0] xv);
        int seg, frac, b, n, p, q;
        seg = int'(xv[7:4]);
        frac = int'(xv[3:0]);
        b = int'(sig_entry(seg));
        if (seg == 7)       n = b;
        else if (seg == 15) n = int'(sig_entry(0));
        else                n = int'(sig_entry(seg + 1));
        p = (n - b) * frac;
`ifdef LUT_INTERP_ROUND_EN
        p = p + 8;
`endif
        q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        return b + q;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (y !== 8'sd0) begin fails++; $display("FAIL reset_y: got %0d expected 0", y); end
        tests++; if (lut_address !== 4'd0) begin fails++; $display("FAIL reset_lut_address: got %0d expected 0", lut_address); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic signed [7:0] e;
        lut_mode = 0;
        @(negedge clk);
        x = 8'h25; in_valid = 1'b1; out_ready = 1'b1;
        expq.push_back(8'sd37);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 1) begin
                tests++; if (lut_address !== 4'd2) begin fails++; $display("FAIL latency_lut_address: got %0d expected 2", lut_address); end
            end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early: cycle %0d out_valid %b expected 0", c, out_valid); end
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL latency_valid: got %b expected 1 after 3 edges", out_valid);
            void'(expq.pop_front());
        end else begin
            e = expq.pop_front();
            tests++; if (y !== e) begin fails++; $display("FAIL latency_y: got %0d expected %0d", y, e); end
        end
    endtask

    task automatic test_lut_edges();
        logic [7:0] xs[2] = '{8'h7A, 8'hF8};
        logic signed [7:0] es[2] = '{8'sd112, -8'sd8};
        logic signed [7:0] e;
        int waited;
        lut_mode = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            x = xs[i]; in_valid = 1'b1; out_ready = 1'b1;
            expq.push_back(es[i]);
            @(negedge clk);
            in_valid = 1'b0;
            waited = 0;
            while (!out_valid && waited < 6) begin @(negedge clk); waited++; end
            tests++;
            e = expq.pop_front();
            if (!out_valid) begin fails++; $display("FAIL edge_timeout: x=%h no output", xs[i]); end
            else if (y !== e) begin fails++; $display("FAIL edge_y: x=%h got %0d expected %0d", xs[i], y, e); end
        end
    endtask

    task automatic test_round();
        int modes[2] = '{1, 2};
`ifdef LUT_INTERP_ROUND_EN
        logic signed [7:0] es[2] = '{8'sd11, 8'sd9};
`else
        logic signed [7:0] es[2] = '{8'sd10, 8'sd9};
`endif
        logic signed [7:0] e;
        int waited;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            lut_mode = modes[i];
            x = 8'h05; in_valid = 1'b1; out_ready = 1'b1;
            expq.push_back(es[i]);
            @(negedge clk);
            in_valid = 1'b0;
            waited = 0;
            while (!out_valid && waited < 6) begin @(negedge clk); waited++; end
            tests++;
            e = expq.pop_front();
            if (!out_valid) begin fails++; $display("FAIL round_timeout: mode %0d no output", modes[i]); end
            else if (y !== e) begin fails++; $display("FAIL round_y: mode %0d got %0d expected %0d", modes[i], y, e); end
        end
        @(negedge clk);
        lut_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs[8] = '{8'h13, 8'h2F, 8'h40, 8'h5A, 8'h87, 8'h9C, 8'hB1, 8'hE6};
        logic signed [7:0] held, e;
        logic ov;
        int sent = 0, got = 0, c = 0;
        lut_mode = 0;
        expq.delete();
        held = '0;
        while (got < 8 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            #1;
            ov = out_valid;
            if (c >= 3 && c <= 7) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", c, in_ready); end
                if (c == 3) held = y;
                else begin
                    tests++;
                    if (ov !== 1'b1 || y !== held) begin fails++; $display("FAIL stall_hold: cycle %0d valid %b y %0d expected valid 1 y %0d", c, ov, y, held); end
                end
            end
            if (ov && out_ready) begin
                tests++;
                if (expq.size() == 0) begin fails++; $display("FAIL b2b_extra: unexpected output y %0d", y); end
                else begin
                    e = expq.pop_front();
                    if (y !== e) begin fails++; $display("FAIL b2b_y: result %0d got %0d expected %0d", got, y, e); end
                end
                got++;
            end
            if (sent < 8) begin
                x = xs[sent]; in_valid = 1'b1;
                if (!ov || out_ready) begin expq.push_back(8'(model_y(xs[sent]))); sent++; end
            end else begin
                in_valid = 1'b0;
            end
            c++;
        end
        in_valid = 1'b0;
        tests++; if (got != 8) begin fails++; $display("FAIL b2b_count: got %0d results expected 8", got); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_dup: out_valid %b expected 0 after drain", out_valid); end
        tests++; if (expq.size() != 0) begin fails++; $display("FAIL b2b_left: %0d pending expected 0", expq.size()); end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] xs[4] = '{8'h25, 8'h31, 8'h52, 8'h66};
        logic signed [7:0] e;
        lut_mode = 0;
        expq.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = xs[i]; in_valid = 1'b1;
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || y !== 8'sd37) begin fails++; $display("FAIL midreset_pre: valid %b y %0d expected valid 1 y 37", out_valid, y); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
        tests++; if (y !== 8'sd0) begin fails++; $display("FAIL midreset_y: got %0d expected 0", y); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        tests++; if (lut_address !== 4'd0) begin fails++; $display("FAIL midreset_addr: got %0d expected 0", lut_address); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        x = 8'h7A; in_valid = 1'b1;
        expq.push_back(8'sd112);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_stale: cycle %0d out_valid %b expected 0", c, out_valid); end
        end
        @(negedge clk);
        tests++;
        e = expq.pop_front();
        if (out_valid !== 1'b1) begin fails++; $display("FAIL midreset_latency: got valid %b expected 1", out_valid); end
        else if (y !== e) begin fails++; $display("FAIL midreset_y_after: got %0d expected %0d", y, e); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_lut_edges();
        test_round();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
